// File: rtl/system_subtractor.sv
// Registered WIDTH-bit subtractor slice: two independently loaded operand
// registers and a captured difference with borrow-in and borrow-out.
module system_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d_a,
  input  logic [WIDTH-1:0] d_b,
  input  logic             en_a,
  input  logic             en_b,
  input  logic             en_result,
  input  logic             bin,
  output logic [WIDTH-1:0] result,
  output logic             bout
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_reg;
  logic             bout_reg;

  logic [WIDTH:0]   full_next;
  logic [WIDTH-1:0] diff_next;
  logic             borrow_next;

  // The extra top bit of the WIDTH+1 difference goes negative exactly when
  // a < b + bin, so it doubles as the borrow-out.
  always_comb begin
    full_next   = {1'b0, a_reg} - {1'b0, b_reg} - {{WIDTH{1'b0}}, bin};
    diff_next   = full_next[WIDTH-1:0];
    borrow_next = full_next[WIDTH];
  end

  // rstn is active-high.
  always_ff @(posedge clk) begin
    if (rstn) begin
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      bout_reg   <= 1'b0;
    end else begin
      if (en_a) begin
        a_reg <= d_a;
      end
      if (en_b) begin
        b_reg <= d_b;
      end
      // Uses operand values from before this edge, even if they reload now.
      if (en_result) begin
        result_reg <= diff_next;
        bout_reg   <= borrow_next;
      end
    end
  end

  assign result = result_reg;
  assign bout   = bout_reg;

endmodule

// File: tb/tb_system_subtractor.sv
// Self-checking bench for system_subtractor: directed plan values plus
// randomized sequences compared against an arithmetic reference model.
module tb_system_subtractor;

  localparam int WIDTH = 16;
  localparam int MODV  = 1 << WIDTH;

  logic             clk;
  logic             rstn;
  logic [WIDTH-1:0] d_a;
  logic [WIDTH-1:0] d_b;
  logic             en_a;
  logic             en_b;
  logic             en_result;
  logic             bin;
  logic [WIDTH-1:0] result;
  logic             bout;

  int check_count;
  int pass_count;

  // reference state kept as plain integers
  int ref_a;
  int ref_b;
  int ref_result;
  int ref_bout;

  system_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .d_a       (d_a),
    .d_b       (d_b),
    .en_a      (en_a),
    .en_b      (en_b),
    .en_result (en_result),
    .bin       (bin),
    .result    (result),
    .bout      (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    check_count++;
    if (obs !== exp) begin
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end else begin
      pass_count++;
    end
  endtask

  // One clock cycle: drive inputs, update the model at the edge, check outputs.
  task automatic cycle(input string tag, input logic rst, input logic ea,
                       input logic eb, input logic er, input logic bi,
                       input int da, input int db);
    int f;
    int new_a;
    int new_b;
    @(negedge clk);
    rstn      = rst;
    en_a      = ea;
    en_b      = eb;
    en_result = er;
    bin       = bi;
    d_a       = da[WIDTH-1:0];
    d_b       = db[WIDTH-1:0];
    @(posedge clk);
    if (rst) begin
      ref_a = 0; ref_b = 0; ref_result = 0; ref_bout = 0;
    end else begin
      new_a = ea ? (da % MODV) : ref_a;
      new_b = eb ? (db % MODV) : ref_b;
      if (er) begin
        f = ref_a - ref_b - int'(bi);
        ref_result = (f < 0) ? f + MODV : f;
        ref_bout   = (ref_a < ref_b + int'(bi)) ? 1 : 0;
      end
      ref_a = new_a;
      ref_b = new_b;
    end
    #1;
    check_val({tag, ".result"}, int'(result), ref_result);
    check_val({tag, ".bout"}, int'(bout), ref_bout);
    $display("txn %-10s rst=%0b ea=%0b eb=%0b er=%0b bin=%0b da=%0d db=%0d -> result=%0d bout=%0b",
             tag, rst, ea, eb, er, bi, da, db, result, bout);
  endtask

  // Check outputs against constants taken straight from the test plan.
  task automatic expect_out(input string tag, input int r, input int b);
    check_val({tag, ".plan_result"}, int'(result), r);
    check_val({tag, ".plan_bout"}, int'(bout), b);
  endtask

  task automatic compute(input string tag, input int a, input int b, input logic bi);
    cycle({tag, "_ld"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, a, b);
    cycle({tag, "_er"}, 1'b0, 1'b0, 1'b0, 1'b1, bi, 0, 0);
  endtask

  function automatic int pick_data();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 1;
      2:       return MODV - 1;
      default: return int'($urandom_range(0, MODV - 1));
    endcase
  endfunction

  initial begin
    check_count = 0;
    pass_count  = 0;
    ref_a = 0; ref_b = 0; ref_result = 0; ref_bout = 0;
    rstn = 1'b1; en_a = 1'b0; en_b = 1'b0; en_result = 1'b0; bin = 1'b0;
    d_a = '0; d_b = '0;

    // 1: reset, then sequential loads
    cycle("rst0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    cycle("rst1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    expect_out("reset", 0, 0);
    cycle("ld_a150", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 150, 0);
    expect_out("before_er1", 0, 0);
    cycle("ld_b50", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 50);
    expect_out("before_er2", 0, 0);
    cycle("er1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    expect_out("t1", 100, 0);

    // 2: borrow, then reload A only
    compute("t2a", 100, 200, 1'b0);
    expect_out("t2a", 65436, 1);
    cycle("t2b_ld", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 500, 0);
    cycle("t2b_er", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    expect_out("t2b", 300, 0);

    // 3: borrow-in and edge values
    compute("t3a", 300, 200, 1'b1);
    expect_out("t3a", 99, 0);
    compute("t3b", 0, 1, 1'b0);
    expect_out("t3b", 65535, 1);
    compute("t3c", 65535, 1, 1'b0);
    expect_out("t3c", 65534, 0);
    compute("t3d", 0, 65535, 1'b1);
    expect_out("t3d", 0, 1);

    // 4: hold with enables low
    compute("t4", 1000, 500, 1'b0);
    expect_out("t4", 500, 0);
    for (int i = 0; i < 4; i++) begin
      cycle("hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2000, 1000);
    end
    expect_out("t4_hold", 500, 0);

    // 5: reset discards, then recompute
    compute("t5a", 300, 100, 1'b0);
    expect_out("t5a", 200, 0);
    cycle("t5_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7, 3);
    expect_out("t5_rst", 0, 0);
    compute("t5b", 12345, 5432, 1'b0);
    expect_out("t5b", 6913, 0);

    // 6: same-cycle load and capture uses old operand
    compute("t6a", 10, 3, 1'b0);
    expect_out("t6a", 7, 0);
    cycle("t6b", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 50, 0);
    expect_out("t6b", 7, 0);
    cycle("t6c", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    expect_out("t6c", 47, 0);

    // randomized sequences against the model
    for (int i = 0; i < 300; i++) begin
      cycle("rand", ($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            pick_data(), pick_data());
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/system_subtractor.md
Name: system_subtractor

Overview:
Registered 16-bit subtractor with borrow-in and borrow-out. Two operand registers A and B are loaded independently from data inputs under separate enables. A third enable captures A − B − bin into a result register and a borrow-out flag. The block is a standalone datapath slice, sequenced by an external controller one enable pulse at a time.

Parameters:
WIDTH, 16, width of the operands, the operand registers and the result.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rstn  input  1  synchronous reset, active-high despite the name. rstn=1 at a rising clk edge resets the block.
d_a  input  WIDTH  operand A data.
d_b  input  WIDTH  operand B data.
en_a  input  1  load enable for operand register A.
en_b  input  1  load enable for operand register B.
en_result  input  1  capture enable for the result and bout registers.
bin  input  1  borrow-in, sampled live at the en_result edge (not registered separately).
result  output  WIDTH  registered difference.
bout  output  1  registered borrow-out.

Behaviour:
- Reset (rstn=1 at a posedge): reg_a=0, reg_b=0, result=0, bout=0. Reset has priority over all enables. Reset mid-sequence discards loaded operands.
- en_a=1 at a posedge: reg_a <= d_a. Otherwise reg_a holds.
- en_b=1 at a posedge: reg_b <= d_b. Otherwise reg_b holds. en_a and en_b are independent and may be asserted together.
- Arithmetic: full = {1'b0,reg_a} − {1'b0,reg_b} − bin, computed at WIDTH+1 bits.
  - diff = full[WIDTH-1:0], i.e. modulo 2^WIDTH wrap-around.
  - borrow = 1 iff reg_a < reg_b + bin, taken as unsigned with no overflow of the sum.
- en_result=1 at a posedge: result <= diff, bout <= borrow, using the register values present before that edge.
  - If en_a or en_b is asserted in the same cycle as en_result, the old operand values are used.
  - The new operands take effect for an en_result asserted in a later cycle.
- Latency: the operand load edge is followed by an en_result edge at least one cycle later. result and bout are valid immediately after the en_result edge.
- Without en_result, result and bout hold indefinitely, regardless of changes on d_a, d_b, bin, en_a or en_b.
- There is no combinational path from any input to the outputs.

Test Plan:
1. Assert reset for 1+ cycles, then release → result=0, bout=0. Load A=150 (en_a), then B=50 (en_b), then pulse en_result with bin=0 → result=100, bout=0. result stays at 0 until the en_result edge.
2. Borrow and partial reload:
   - Load A=100 and B=200 in the same cycle, bin=0, then en_result → result=65436, bout=1.
   - Then reload only A=500 and pulse en_result → result=300, bout=0, using the retained B=200.
3. Borrow-in and edge values:
   - A=300, B=200, bin=1, then en_result → result=99, bout=0.
   - A=0, B=1, bin=0 → result=65535, bout=1.
   - A=65535, B=1 → result=65534, bout=0.
   - A=0, B=65535, bin=1 → result=0, bout=1.
4. Hold:
   - After A=1000, B=500, en_result → result=500.
   - Change d_a=2000, d_b=1000 with all enables low for several cycles → result stays 500, bout stays 0.
5. Reset and recompute:
   - After 300−100 → result=200, assert reset for 1 cycle → result=0, bout=0.
   - Then load A=12345, B=5432, bin=0, en_result → result=6913, bout=0.
6. Same-cycle ordering: with reg_a=10, reg_b=3, assert en_a with d_a=50 together with en_result → result=7. A following en_result → result=47.
